// File: rtl/bram_read_arbiter.sv
// Round-robin read arbiter for the shared matrix BRAM read port.
// A requester may lock the port for a burst; a watchdog breaks locks that
// are held too long. Read data returns to the issuing requester after
// RD_LATENCY cycles through a {valid, index} shift register.
module bram_read_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_lock,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [ADDR_WIDTH-1:0]           bram_rd_addr,
  input  logic [DATA_WIDTH-1:0]           bram_rd_data,
  output logic [$clog2(NUM_REQ):0]        owner,
  output logic                            lock_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX);

  logic [IDX_W-1:0]                  rr_q, rr_d;
  logic                              lock_q, lock_d;
  logic [IDX_W-1:0]                  own_q, own_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              timeout_q, timeout_d;
  logic [NUM_REQ-1:0]                ign_q, ign_d;
  logic [ADDR_WIDTH-1:0]             last_addr_q, last_addr_d;
  logic [RD_LATENCY-1:0]             ret_vld_q, ret_vld_d;
  logic [RD_LATENCY-1:0][IDX_W-1:0]  ret_idx_q, ret_idx_d;

  logic                              gnt_vld;
  logic [IDX_W-1:0]                  gnt_idx;
  logic                              rel_wd, rel_beat, rel_idle;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Grant selection and port-facing outputs (combinational within the cycle)
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!rst) begin
      if (lock_q) begin
        if (req_valid[own_q]) begin
          gnt_vld = 1'b1;
          gnt_idx = own_q;
        end
      end else begin
        // Walk from the farthest candidate back to rr_q so the nearest wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          automatic int c = int'(rr_q) + k;
          if (c >= NUM_REQ) c = c - NUM_REQ;
          if (req_valid[c]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(c);
          end
        end
      end
    end
    req_ready    = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    bram_rd_addr = gnt_vld ? req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH] : last_addr_q;
    rd_valid     = ret_vld_q[RD_LATENCY-1] ? (NUM_REQ'(1) << ret_idx_q[RD_LATENCY-1]) : '0;
    rd_data      = ret_vld_q[RD_LATENCY-1] ? bram_rd_data : '0;
    owner        = lock_q ? {1'b1, own_q} : '0;
    lock_timeout = timeout_q;
  end

  // Next state: pointer, lock ownership, watchdog and return pipeline
  always_comb begin
    rr_d        = rr_q;
    lock_d      = lock_q;
    own_d       = own_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    ign_d       = ign_q;
    last_addr_d = bram_rd_addr;
    ret_vld_d   = ret_vld_q;
    ret_idx_d   = ret_idx_q;

    rel_wd   = lock_q && (cnt_q == CNT_W'(LOCK_MAX - 1));
    rel_beat = lock_q && gnt_vld && !req_lock[own_q];
    rel_idle = lock_q && !req_valid[own_q] && !req_lock[own_q];

    // A force-released requester stays unlockable until its current request ends.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_lock[i] || (gnt_vld && (int'(gnt_idx) == i))) ign_d[i] = 1'b0;
    end

    if (lock_q) begin
      cnt_d = cnt_q + 1'b1;
      if (rel_wd || rel_beat || rel_idle) begin
        lock_d = 1'b0;
        cnt_d  = '0;
        rr_d   = next_idx(own_q);
      end
      if (rel_wd) begin
        timeout_d    = 1'b1;
        ign_d[own_q] = 1'b1;
      end
    end else if (gnt_vld) begin
      rr_d = next_idx(gnt_idx);
      if (req_lock[gnt_idx] && !ign_q[gnt_idx]) begin
        lock_d = 1'b1;
        own_d  = gnt_idx;
        cnt_d  = '0;
      end
    end

    for (int k = RD_LATENCY - 1; k > 0; k--) begin
      ret_vld_d[k] = ret_vld_q[k-1];
      ret_idx_d[k] = ret_idx_q[k-1];
    end
    ret_vld_d[0] = gnt_vld;
    ret_idx_d[0] = gnt_idx;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      own_q       <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      ign_q       <= '0;
      last_addr_q <= '0;
      ret_vld_q   <= '0;
      ret_idx_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      ign_q       <= ign_d;
      last_addr_q <= last_addr_d;
      ret_vld_q   <= ret_vld_d;
      ret_idx_q   <= ret_idx_d;
    end
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: instance a (RD_LATENCY=1, LOCK_MAX=16) and
// instance b (RD_LATENCY=3), each with a behavioural BRAM and a return scoreboard.
module tb_bram_read_arbiter;
  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec  = 0;
  int errs = 0;

  logic [N-1:0]    a_req_valid = '0, a_req_lock = '0, a_req_ready, a_rd_valid;
  logic [N*AW-1:0] a_req_addr = '0;
  logic [DW-1:0]   a_rd_data, a_bram_rd_data;
  logic [AW-1:0]   a_bram_rd_addr;
  logic [2:0]      a_owner;
  logic            a_lock_timeout;

  logic [N-1:0]    b_req_valid = '0, b_req_lock = '0, b_req_ready, b_rd_valid;
  logic [N*AW-1:0] b_req_addr = '0;
  logic [DW-1:0]   b_rd_data, b_bram_rd_data;
  logic [AW-1:0]   b_bram_rd_addr;
  logic [2:0]      b_owner;
  logic            b_lock_timeout;

  bram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .LOCK_MAX(16)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_addr(a_req_addr), .req_lock(a_req_lock),
    .req_ready(a_req_ready), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .bram_rd_addr(a_bram_rd_addr), .bram_rd_data(a_bram_rd_data),
    .owner(a_owner), .lock_timeout(a_lock_timeout));

  bram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .LOCK_MAX(4096)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_addr(b_req_addr), .req_lock(b_req_lock),
    .req_ready(b_req_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .bram_rd_addr(b_bram_rd_addr), .bram_rd_data(b_bram_rd_data),
    .owner(b_owner), .lock_timeout(b_lock_timeout));

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] ad);
    return {2'b10, ad, 2'b01, ~ad};
  endfunction

  // Behavioural BRAMs with 1- and 3-cycle read latency
  logic [AW-1:0] a_m1, b_m1, b_m2, b_m3;
  always @(posedge clk) begin
    a_m1 <= a_bram_rd_addr;
    b_m1 <= b_bram_rd_addr;
    b_m2 <= b_m1;
    b_m3 <= b_m2;
  end
  assign a_bram_rd_data = mem(a_m1);
  assign b_bram_rd_data = mem(b_m3);

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    int            cyc;
  } sb_t;
  sb_t qa[$];
  sb_t qb[$];

  sb_t        ea, eb;
  logic [2:0] ea_exp, eb_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (qa.size() > 0 && qa[0].cyc == cyc) begin
        ea = qa.pop_front();
        ea_exp = 3'b001 << ea.idx;
        vec++;
        if (a_rd_valid !== ea_exp || a_rd_data !== mem(ea.addr)) begin
          errs++;
          $display("FAIL a_return cyc=%0d: rd_valid=%b rd_data=%h, required rd_valid=%b rd_data=%h",
                   cyc, a_rd_valid, a_rd_data, ea_exp, mem(ea.addr));
        end
      end else if (a_rd_valid !== 3'b000) begin
        vec++;
        errs++;
        $display("FAIL a_spurious cyc=%0d: rd_valid=%b, required 000", cyc, a_rd_valid);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (qb.size() > 0 && qb[0].cyc == cyc) begin
        eb = qb.pop_front();
        eb_exp = 3'b001 << eb.idx;
        vec++;
        if (b_rd_valid !== eb_exp || b_rd_data !== mem(eb.addr)) begin
          errs++;
          $display("FAIL b_return cyc=%0d: rd_valid=%b rd_data=%h, required rd_valid=%b rd_data=%h",
                   cyc, b_rd_valid, b_rd_data, eb_exp, mem(eb.addr));
        end
      end else if (b_rd_valid !== 3'b000) begin
        vec++;
        errs++;
        $display("FAIL b_spurious cyc=%0d: rd_valid=%b, required 000", cyc, b_rd_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    a_req_valid = '0; a_req_lock = '0; a_req_addr = '0;
    b_req_valid = '0; b_req_lock = '0; b_req_addr = '0;
    qa.delete();
    qb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req_valid = 3'b111;
    b_req_valid = 3'b111;
    @(negedge clk);
    vec++;
    if ({a_req_ready, a_rd_valid, a_rd_data, a_bram_rd_addr, a_owner, a_lock_timeout} !== '0) begin
      errs++;
      $display("FAIL a_reset_outputs: ready=%b rd_valid=%b rd_data=%h addr=%h owner=%b to=%b, required all 0",
               a_req_ready, a_rd_valid, a_rd_data, a_bram_rd_addr, a_owner, a_lock_timeout);
    end
    vec++;
    if ({b_req_ready, b_rd_valid, b_rd_data, b_bram_rd_addr, b_owner, b_lock_timeout} !== '0) begin
      errs++;
      $display("FAIL b_reset_outputs: ready=%b rd_valid=%b rd_data=%h addr=%h owner=%b to=%b, required all 0",
               b_req_ready, b_rd_valid, b_rd_data, b_bram_rd_addr, b_owner, b_lock_timeout);
    end
    tick();
    a_req_valid = '0;
    b_req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    pulse_reset();
    tick();
    a_req_valid = 3'b010;
    a_req_addr[AW +: AW] = 14'h0010;
    @(negedge clk);
    vec++;
    if (a_req_ready !== 3'b010) begin
      errs++; $display("FAIL single_ready: got %b, required 010", a_req_ready);
    end
    vec++;
    if (a_bram_rd_addr !== 14'h0010) begin
      errs++; $display("FAIL single_addr: got %h, required 0010", a_bram_rd_addr);
    end
    qa.push_back('{idx: 1, addr: 14'h0010, cyc: cyc + 1});
    tick();
    a_req_valid = '0;
    a_req_addr[AW +: AW] = 14'h3fff;
    @(negedge clk);
    vec++;
    if (a_req_ready !== 3'b000) begin
      errs++; $display("FAIL single_idle_ready: got %b, required 000", a_req_ready);
    end
    vec++;
    if (a_bram_rd_addr !== 14'h0010) begin
      errs++; $display("FAIL single_addr_hold: got %h, required 0010", a_bram_rd_addr);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ad[3];
    logic [2:0]    er;
    int            g;
    pulse_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      ad[i] = 14'h0020 + 14'(i);
      a_req_addr[i*AW +: AW] = ad[i];
    end
    a_req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g  = k % 3;
      er = 3'b001 << g;
      vec++;
      if (a_req_ready !== er) begin
        errs++; $display("FAIL rr_ready beat %0d: got %b, required %b", k, a_req_ready, er);
      end
      vec++;
      if (a_bram_rd_addr !== ad[g]) begin
        errs++; $display("FAIL rr_addr beat %0d: got %h, required %h", k, a_bram_rd_addr, ad[g]);
      end
      qa.push_back('{idx: g, addr: ad[g], cyc: cyc + 1});
      tick();
      ad[g] = ad[g] + 14'd3;
      a_req_addr[g*AW +: AW] = ad[g];
    end
    a_req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lock();
    logic [AW-1:0] ad;
    pulse_reset();
    tick();
    a_req_valid = 3'b010;
    a_req_lock  = 3'b010;
    a_req_addr[AW +: AW] = 14'h0100;
    @(negedge clk);
    vec++;
    if (a_req_ready !== 3'b010 || a_owner !== 3'b000) begin
      errs++; $display("FAIL lock_first_beat: ready=%b owner=%b, required 010 000", a_req_ready, a_owner);
    end
    qa.push_back('{idx: 1, addr: 14'h0100, cyc: cyc + 1});
    for (int b = 1; b < 8; b++) begin
      tick();
      ad = 14'h0100 + 14'(b);
      a_req_addr[AW +: AW] = ad;
      a_req_lock[1] = (b < 7);
      a_req_valid = 3'b011;
      a_req_addr[0 +: AW] = 14'h0040;
      @(negedge clk);
      vec++;
      if (a_req_ready !== 3'b010 || a_owner !== 3'b101) begin
        errs++; $display("FAIL lock_beat %0d: ready=%b owner=%b, required 010 101", b, a_req_ready, a_owner);
      end
      qa.push_back('{idx: 1, addr: ad, cyc: cyc + 1});
    end
    tick();
    a_req_valid = 3'b001;
    a_req_lock  = '0;
    @(negedge clk);
    vec++;
    if (a_req_ready !== 3'b001 || a_owner !== 3'b000 || a_bram_rd_addr !== 14'h0040) begin
      errs++; $display("FAIL lock_after_release: ready=%b owner=%b addr=%h, required 001 000 0040",
                       a_req_ready, a_owner, a_bram_rd_addr);
    end
    qa.push_back('{idx: 0, addr: 14'h0040, cyc: cyc + 1});
    tick();
    a_req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency3();
    pulse_reset();
    tick();
    b_req_valid = 3'b101;
    b_req_addr[0 +: AW]    = 14'h0200;
    b_req_addr[2*AW +: AW] = 14'h0300;
    @(negedge clk);
    vec++;
    if (b_req_ready !== 3'b001 || b_bram_rd_addr !== 14'h0200) begin
      errs++; $display("FAIL lat3_beat0: ready=%b addr=%h, required 001 0200", b_req_ready, b_bram_rd_addr);
    end
    qb.push_back('{idx: 0, addr: 14'h0200, cyc: cyc + 3});
    tick();
    b_req_addr[0 +: AW] = 14'h0201;
    @(negedge clk);
    vec++;
    if (b_req_ready !== 3'b100 || b_bram_rd_addr !== 14'h0300) begin
      errs++; $display("FAIL lat3_beat1: ready=%b addr=%h, required 100 0300", b_req_ready, b_bram_rd_addr);
    end
    qb.push_back('{idx: 2, addr: 14'h0300, cyc: cyc + 3});
    tick();
    b_req_valid = 3'b001;
    @(negedge clk);
    vec++;
    if (b_req_ready !== 3'b001 || b_bram_rd_addr !== 14'h0201) begin
      errs++; $display("FAIL lat3_beat2: ready=%b addr=%h, required 001 0201", b_req_ready, b_bram_rd_addr);
    end
    qb.push_back('{idx: 0, addr: 14'h0201, cyc: cyc + 3});
    tick();
    b_req_valid = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_watchdog();
    pulse_reset();
    tick();
    a_req_valid = 3'b100;
    a_req_lock  = 3'b100;
    a_req_addr[2*AW +: AW] = 14'h0050;
    @(negedge clk);
    vec++;
    if (a_req_ready !== 3'b100) begin
      errs++; $display("FAIL wd_acquire: ready=%b, required 100", a_req_ready);
    end
    qa.push_back('{idx: 2, addr: 14'h0050, cyc: cyc + 1});
    tick();
    a_req_valid = 3'b001;
    a_req_addr[0 +: AW] = 14'h0060;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      vec++;
      if (a_req_ready !== 3'b000 || a_owner !== 3'b110 || a_lock_timeout !== 1'b0) begin
        errs++; $display("FAIL wd_locked cycle %0d: ready=%b owner=%b to=%b, required 000 110 0",
                         c, a_req_ready, a_owner, a_lock_timeout);
      end
      tick();
    end
    @(negedge clk);
    vec++;
    if (a_req_ready !== 3'b001 || a_owner !== 3'b000 || a_lock_timeout !== 1'b1) begin
      errs++; $display("FAIL wd_released: ready=%b owner=%b to=%b, required 001 000 1",
                       a_req_ready, a_owner, a_lock_timeout);
    end
    qa.push_back('{idx: 0, addr: 14'h0060, cyc: cyc + 1});
    tick();
    a_req_valid = '0;
    repeat (4) @(negedge clk);
    vec++;
    if (a_lock_timeout !== 1'b1 || a_owner !== 3'b000) begin
      errs++; $display("FAIL wd_sticky: to=%b owner=%b, required 1 000", a_lock_timeout, a_owner);
    end
    pulse_reset();
    @(negedge clk);
    vec++;
    if (a_lock_timeout !== 1'b0) begin
      errs++; $display("FAIL wd_cleared_by_rst: to=%b, required 0", a_lock_timeout);
    end
  endtask

  task automatic test_reset_inflight();
    logic [2:0] er;
    pulse_reset();
    tick();
    for (int i = 0; i < 3; i++) b_req_addr[i*AW +: AW] = 14'h0010 + 14'(i);
    b_req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      er = 3'b001 << k;
      vec++;
      if (b_req_ready !== er) begin
        errs++; $display("FAIL inflight_accept %0d: ready=%b, required %b", k, b_req_ready, er);
      end
      tick();
    end
    rst = 1'b1;
    b_req_valid = '0;
    #1;
    vec++;
    if ({b_req_ready, b_rd_valid, b_rd_data, b_bram_rd_addr, b_owner, b_lock_timeout} !== '0) begin
      errs++; $display("FAIL inflight_async_reset: ready=%b rd_valid=%b rd_data=%h addr=%h owner=%b, required all 0",
                       b_req_ready, b_rd_valid, b_rd_data, b_bram_rd_addr, b_owner);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++;
      if (b_rd_valid !== 3'b000) begin
        errs++; $display("FAIL inflight_after_rst cycle %0d: rd_valid=%b, required 000", c, b_rd_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_latency3();
    test_watchdog();
    test_reset_inflight();
    repeat (2) @(negedge clk);
    vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errs++; $display("FAIL missing_returns: pending a=%0d b=%0d, required 0 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/bram_read_arbiter.md
Name: bram_read_arbiter

Overview:
- Shares the single matrix-BRAM read port among NUM_REQ requesters: selector, executor, and a future UART matrix dumper.
- Replaces the state-based read-address mux in the compute subsystem with valid/ready round-robin arbitration.
- Supports a lock for burst ownership, with a lock watchdog.
- Routes returned read data back to the issuing requester after the fixed BRAM latency.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = selector, 1 = executor, 2 = dumper).
- ADDR_WIDTH, 14, BRAM address width.
- DATA_WIDTH, 32, BRAM data width.
- RD_LATENCY, 1, clock cycles from address sampled by BRAM to data valid (legal values 1..4).
- LOCK_MAX, 4096, maximum cycles a lock may be held before forced release.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester read request
- req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address (slice i = requester i)
- req_lock  input  NUM_REQ  keep ownership after this beat
- req_ready  output  NUM_REQ  request accepted this cycle (one-hot or zero)
- rd_valid  output  NUM_REQ  return data valid for requester i
- rd_data  output  DATA_WIDTH  return data (shared, qualified by rd_valid)
- bram_rd_addr  output  ADDR_WIDTH  to BRAM read port
- bram_rd_data  input  DATA_WIDTH  from BRAM read port
- owner  output  $clog2(NUM_REQ)+1  MSB = lock active; LSBs = locked requester index
- lock_timeout  output  1  sticky flag: a lock was force-released

Behaviour:
- Reset: req_ready=0, rd_valid=0, rd_data=0, bram_rd_addr=0, owner=0, lock_timeout=0, rr pointer=0, lock counter=0, return pipeline cleared. Reset mid-burst discards all in-flight returns.
- Arbitration is combinational within the cycle.
  - Unlocked: grant the first i with req_valid[i], searching from the rr pointer upward and wrapping.
  - Locked: only the owner can be granted; other requesters see req_ready=0.
- req_ready[i]=1 only for the granted requester. Accept = req_valid[i] && req_ready[i]. Requesters must hold addr/valid stable until accepted.
- bram_rd_addr = req_addr of the granted requester while granted. When no grant, it holds the last accepted address (registered copy) so the BRAM output stays stable.
- Throughput: one accept per cycle; back-to-back accepts from the same or different requesters are allowed.
- Return path: accept at cycle T gives rd_valid[i]=1 for exactly one cycle at T+RD_LATENCY, with rd_data=bram_rd_data in that cycle.
  - Implement with a RD_LATENCY-deep shift register of {valid, index}.
  - Returns are in-order; never more than one rd_valid bit high.
- rr pointer: after an unlocked accept by i, pointer = (i+1) mod NUM_REQ. Unchanged during a locked accept and on idle cycles.
- Lock acquire: accept by i with req_lock[i]=1 → owner={1,i} from the next cycle; lock counter=0.
- Lock release, whichever happens first:
  - an accept by the owner with req_lock=0 (that beat is the last locked beat), or
  - owner req_valid=0 && req_lock=0 in any cycle.
  - On release, pointer = owner+1.
- Watchdog: counter increments each cycle while locked. When it reaches LOCK_MAX-1, force release on the next edge, set lock_timeout (sticky until rst), and treat the owner as unlocked for the rest of its current request.
- Simultaneous: release and a new request in the same cycle → release takes effect at the edge; the new request is arbitrated with the updated pointer next cycle.
- An accepted address is never dropped. An address with req_ready=0 is never sampled.

Test Plan:
- Single requester 1 reads addr 0x0010, RD_LATENCY=1 → req_ready[1] same cycle, bram_rd_addr=0x0010, rd_valid[1] next cycle with rd_data=BRAM word; all other rd_valid stay 0.
- All three requesters hold valid continuously, no locks → accept order 0,1,2,0,1,2; each rd_valid appears exactly 1 cycle after its accept, in matching order.
- Requester 1 locks and issues 8 reads (0x100..0x107) while requester 0 requests → requester 0 gets req_ready=0 for all 8 beats; owner=1_01 during the burst; requester 0 is granted the cycle after the unlocked 8th beat.
- RD_LATENCY=3, back-to-back accepts 0,2,0 → rd_valid pattern 0,2,0 on cycles T+3, T+4, T+5 with the correct data per address.
- LOCK_MAX=16, requester 2 holds lock with valid low → forced release after 16 locked cycles, lock_timeout=1; requester 0 is then granted; flag stays 1 until rst.
- Assert rst during a 3-deep in-flight burst → all outputs return to 0 immediately (async); no rd_valid after rst deasserts.
